apb_accum_array: RTL



---
 rtl/apb_accum_array.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/apb_accum_array.sv
// APB slave with NUM_CH masked accumulator channels (XOR / wrapping ADD / saturating ADD),
// sticky write-1-to-clear overflow flags and a fixed number of wait states per transfer.
module apb_accum_array #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int NUM_CH      = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              ovf_irq
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic              latch, commit;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;

    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_write;

    logic [DATA_W-1:0] add_val [NUM_CH];
    logic [DATA_W-1:0] mask    [NUM_CH];
    logic [3:0]        ctrl    [NUM_CH];
    logic [DATA_W-1:0] result  [NUM_CH];
    logic [NUM_CH-1:0] ovf;

    logic [3:0]        ch_sel;
    logic [1:0]        reg_sel;
    logic              is_ch, is_id, is_ovf, err, wr_en;
    logic [DATA_W-1:0] rdata, sel_add, sel_mask, sel_res, t, acc_val;
    logic [DATA_W:0]   sum;
    logic              acc_ovf;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && PENABLE) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 3'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                end else if (cnt == 3'd0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the commit edge is the latching edge, so decode from the live bus
    assign cur_addr  = (state == IDLE) ? PADDR  : addr_q;
    assign cur_wdata = (state == IDLE) ? PWDATA : wdata_q;
    assign cur_write = (state == IDLE) ? PWRITE : write_q;

    always_comb begin
        ch_sel   = cur_addr[7:4];
        reg_sel  = cur_addr[3:2];
        is_ch    = ((cur_addr >> 8) == '0) && ({1'b0, ch_sel} < 5'(NUM_CH));
        is_id    = (cur_addr == ADDR_W'(12'h100));
        is_ovf   = (cur_addr == ADDR_W'(12'h104));
        err      = (cur_addr[1:0] != 2'b00) || !(is_ch || is_id || is_ovf)
                || (cur_write && is_id)
                || (cur_write && is_ch && reg_sel == 2'd3)
                || (cur_write && is_ch && reg_sel == 2'd2 && cur_wdata[3:2] == 2'b11);
        wr_en    = commit && cur_write && !err;
        rdata    = '0;
        sel_add  = '0;
        sel_mask = '0;
        sel_res  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (is_ch && ch_sel == 4'(c)) begin
                sel_add  = add_val[c];
                sel_mask = mask[c];
                sel_res  = result[c];
                case (reg_sel)
                    2'd0:    rdata = add_val[c];
                    2'd1:    rdata = mask[c];
                    2'd2:    rdata = DATA_W'(ctrl[c]);
                    default: rdata = result[c];
                endcase
            end
        end
        if (is_id) begin
            rdata[7:0]  = 8'(NUM_CH);
            rdata[15:8] = 8'(DATA_W);
        end
        if (is_ovf) rdata = DATA_W'(ovf);
        if (err || cur_write) rdata = '0;
    end

    // Accumulate result for the addressed channel under the mode carried by the CTRL write
    always_comb begin
        t       = sel_add & sel_mask;
        sum     = {1'b0, sel_res} + {1'b0, t};
        acc_val = sum[DATA_W-1:0];
        acc_ovf = sum[DATA_W];
        case (cur_wdata[3:2])
            2'b00: begin
                acc_val = sel_res ^ t;
                acc_ovf = 1'b0;
            end
            2'b01:   acc_val = sum[DATA_W-1:0];
            default: acc_val = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int c = 0; c < NUM_CH; c++) begin
                add_val[c] <= '0;
                mask[c]    <= '1;
                ctrl[c]    <= '0;
                result[c]  <= '0;
            end
            ovf <= '0;
        end else if (wr_en) begin
            if (is_ovf) ovf <= ovf & ~cur_wdata[NUM_CH-1:0];
            for (int c = 0; c < NUM_CH; c++) begin
                if (is_ch && ch_sel == 4'(c)) begin
                    case (reg_sel)
                        2'd0: add_val[c] <= cur_wdata;
                        2'd1: mask[c]    <= cur_wdata;
                        2'd2: begin
                            ctrl[c] <= cur_wdata[3:0];
                            case (cur_wdata[1:0])
                                2'b01: begin
                                    result[c] <= acc_val;
                                    if (acc_ovf) ovf[c] <= 1'b1;
                                end
                                2'b10:   result[c] <= '0;
                                2'b11:   result[c] <= add_val[c];
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            ovf_irq <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch) begin
                addr_q  <= PADDR;
                wdata_q <= PWDATA;
                write_q <= PWRITE;
            end
            PREADY  <= commit;
            PSLVERR <= commit && err;
            PRDATA  <= commit ? rdata : '0;
            ovf_irq <= |ovf;
        end
    end

endmodule
